pixel_write_sink: RTL and testbench
===================================

PIXEL_WRITE_SINK -- requirements
Module: pixel_write_sink

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clk input 1 rising-edge clock; resetn input 1 async active-low reset.
REQ-002 SHALL have the following pixel-write inputs:
- wr_en input 1: pixel write strobe from the display controller.
- x_in input 9: pixel column.
- y_in input 8: pixel row.
- c_in input 3: pixel colour.
- frame_done input 1: controller all_done level.
REQ-003 SHALL have the following memory-port signals:
- mem_busy input 1: framebuffer port is held by scan-out.
- mem_we output 1: framebuffer write strobe.
- mem_addr output 17: linear framebuffer address.
- mem_data output 3: colour to write.
REQ-004 SHALL have the following status outputs:
- fifo_full output 1: FIFO holds 8 entries.
- fifo_empty output 1: FIFO holds 0 entries.
- overflow output 1: sticky dropped-write flag.
- frame_ack output 1: one-cycle pulse when a frame has been fully written.
- frame_pixels output 17: pixel count of the last completed frame.
- state_out output 2: current FSM state, for debug.

Function
REQ-005 SHALL buffer incoming writes {x_in, y_in, c_in} in an 8-entry FIFO with 3-bit read and write pointers that wrap from 7 to 0.
REQ-006 SHALL push the FIFO when wr_en=1 and the FIFO is not full.
REQ-007 SHALL also push when wr_en=1 and the FIFO is full, provided a pop occurs in the same cycle; occupancy then stays at 8.
REQ-008 SHALL drop the write and set overflow=1 when wr_en=1, the FIFO is full and no pop occurs; overflow stays set until reset.
REQ-009 SHALL pop one entry per cycle whenever the FIFO is not empty and mem_busy=0.
REQ-010 SHALL register mem_we, mem_addr and mem_data on the cycle after a pop, with mem_we=1 for exactly that one cycle per popped entry.
REQ-011 SHALL compute mem_addr = y*320 + x, zero-extended to 17 bits with no truncation; the maximum legal address is 76799.
REQ-012 SHALL have a latency of one clock from a push into an empty FIFO with mem_busy=0 to mem_we=1.
REQ-013 SHALL never pop while mem_busy=1; queued entries are held, and mem_we=0 during those cycles.
REQ-014 SHALL implement a state machine with the following states and transitions:
- IDLE(0): move to RUN on the first accepted push.
- RUN(1): move to FLUSH on a rising edge of frame_done.
- FLUSH(2): move to ACK once the FIFO is empty and the last mem_we has issued.
- ACK(3): assert frame_ack=1 for one cycle, then return to IDLE.
REQ-015 SHALL keep accepting pushes during FLUSH; FLUSH exits only when the FIFO is empty.
REQ-016 SHALL keep an internal 17-bit pix_count that increments on every mem_we and saturates at 131071.
REQ-017 SHALL copy pix_count to frame_pixels in ACK and clear pix_count in that same cycle.
REQ-018 SHALL count an mem_we that coincides with ACK into the next frame.
REQ-019 SHALL detect the frame_done rising edge against a registered copy of frame_done; a rising edge seen in IDLE moves straight to ACK, giving frame_pixels=0.
REQ-020 SHALL drive fifo_full and fifo_empty combinationally from the FIFO occupancy.

Reset
REQ-021 SHALL, on resetn=0, asynchronously clear the following:
- pointers, occupancy and pix_count to 0.
- mem_we, mem_addr, mem_data, overflow, frame_ack and frame_pixels to 0.
- the state to IDLE, and the registered frame_done copy to 0.
REQ-022 SHALL discard all queued entries when reset asserts mid-operation, with no mem_we issued after reset asserts.

Configuration
REQ-023 SHALL compile a bounds check in when PIXEL_BOUNDS_CHECK_EN is defined: writes with x_in>=320 or y_in>=240 are not pushed, and each such write sets overflow=1.
REQ-024 SHALL, when PIXEL_BOUNDS_CHECK_EN is undefined, push all writes unchecked, with out-of-range addresses passed through as computed.

Verification
REQ-025 A bench SHALL cover the following directed scenarios:
- Single write: x=140, y=5, c=7, mem_busy=0 -> next cycle mem_we=1, mem_addr=1740, mem_data=7.
- Burst under busy: 10 consecutive writes with mem_busy=1 -> 8 queued, fifo_full=1, overflow=1; after release, exactly 8 mem_we with addresses in push order.
- Full with simultaneous push and pop: FIFO full, mem_busy=0, wr_en=1 -> no drop, overflow stays 0, occupancy stays 8.
- Frame flush: 20 writes, frame_done rises while entries remain queued -> state goes through FLUSH, frame_ack pulses once after the last mem_we, frame_pixels=20.
- Async reset: resetn pulsed low mid-burst with 5 entries queued -> all outputs 0 immediately, state IDLE, no further mem_we.
- PIXEL_BOUNDS_CHECK_EN defined: write x=320, y=0 -> no mem_we, overflow=1; the same write with the macro undefined -> mem_we=1 with mem_addr=320.

Source files
------------

// File: rtl/pixel_write_sink.sv
// pixel_write_sink: buffers pixel writes from a display controller in an
// 8-entry FIFO and drains them into a framebuffer port whenever scan-out is
// not holding it. The linear address is y*320 + x. Frames are closed by a
// FLUSH/ACK handshake that reports how many pixels were written.
// Optional feature: define PIXEL_BOUNDS_CHECK_EN to reject off-screen writes
// (x >= 320 or y >= 240). Rejected writes raise the sticky overflow flag.
module pixel_write_sink (
  input  logic        clk,
  input  logic        resetn,
  input  logic        wr_en,
  input  logic [8:0]  x_in,
  input  logic [7:0]  y_in,
  input  logic [2:0]  c_in,
  input  logic        frame_done,
  input  logic        mem_busy,
  output logic        mem_we,
  output logic [16:0] mem_addr,
  output logic [2:0]  mem_data,
  output logic        fifo_full,
  output logic        fifo_empty,
  output logic        overflow,
  output logic        frame_ack,
  output logic [16:0] frame_pixels,
  output logic [1:0]  state_out
);

  localparam logic [1:0]  ST_IDLE  = 2'd0;
  localparam logic [1:0]  ST_RUN   = 2'd1;
  localparam logic [1:0]  ST_FLUSH = 2'd2;
  localparam logic [1:0]  ST_ACK   = 2'd3;
  localparam logic [16:0] PIX_MAX  = 17'h1FFFF;

  // Entry layout: x in [19:11], y in [10:3], colour in [2:0].
  logic [19:0] fifo_mem [8];
  logic [2:0]  wr_ptr;
  logic [2:0]  rd_ptr;
  logic [3:0]  count;

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic        fd_q;
  logic [16:0] pix_count;
  logic [16:0] pix_inc;

  logic        in_range;
  logic        wr_req;
  logic        pop_fifo;
  logic        accept;
  logic        bypass;
  logic        push;
  logic        drop;
  logic        issue;
  logic [19:0] issue_entry;
  logic [16:0] issue_y;
  logic [16:0] issue_x;
  logic [16:0] issue_addr;
  logic        fd_rise;

`ifdef PIXEL_BOUNDS_CHECK_EN
  assign in_range = (x_in < 9'd320) && (y_in < 8'd240);
`else
  assign in_range = 1'b1;
`endif

  assign fifo_full  = (count == 4'd8);
  assign fifo_empty = (count == 4'd0);
  assign state_out  = state;
  assign fd_rise    = frame_done & ~fd_q;

  // A write into an empty FIFO with the port free bypasses storage and goes
  // straight to the output registers, giving single-cycle write latency.
  assign wr_req   = wr_en & in_range;
  assign pop_fifo = ~fifo_empty & ~mem_busy;
  assign accept   = wr_req & (~fifo_full | pop_fifo);
  assign bypass   = accept & fifo_empty & ~mem_busy;
  assign push     = accept & ~bypass;
  assign drop     = wr_en & ~accept;
  assign issue    = pop_fifo | bypass;

  assign issue_entry = pop_fifo ? fifo_mem[rd_ptr] : {x_in, y_in, c_in};
  assign issue_y     = {9'd0, issue_entry[10:3]};
  assign issue_x     = {8'd0, issue_entry[19:11]};
  // y*320 = y*256 + y*64; 17 bits holds the largest 9-bit x / 8-bit y case.
  assign issue_addr  = (issue_y << 8) + (issue_y << 6) + issue_x;

  assign pix_inc = (mem_we && (pix_count != PIX_MAX)) ? pix_count + 17'd1 : pix_count;

  // Next-state logic for the frame handshake.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
    state_nxt = state;
    case (state)
      ST_IDLE:  if (fd_rise) state_nxt = ST_ACK;
                else if (accept) state_nxt = ST_RUN;
      ST_RUN:   if (fd_rise) state_nxt = ST_FLUSH;
      ST_FLUSH: if (fifo_empty && !mem_we) state_nxt = ST_ACK;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // FIFO storage array.
  // NOTE: storage is not reset; pointers and occupancy are, so stale entries are never read.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {x_in, y_in, c_in};
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= 3'd0;
      rd_ptr <= 3'd0;
      count  <= 4'd0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (push)     wr_ptr <= wr_ptr + 3'd1;
      if (pop_fifo) rd_ptr <= rd_ptr + 3'd1;
      case ({push, pop_fifo})
        2'b10:   count <= count + 4'd1;
        2'b01:   count <= count - 4'd1;
        default: count <= count;
      endcase
    end
  end

  // Framebuffer port registers: one mem_we cycle per issued entry.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_we   <= 1'b0;
      mem_addr <= 17'd0;
      mem_data <= 3'd0;
    end else begin
      mem_we <= issue;
      if (issue) begin
        mem_addr <= issue_addr;
        mem_data <= issue_entry[2:0];
      end
    end
  end

  // Sticky overflow flag and frame_done history for edge detection.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      overflow <= 1'b0;
      fd_q     <= 1'b0;
    end else begin
      if (drop) overflow <= 1'b1;
      fd_q <= frame_done;
    end
  end

  // Frame state, acknowledge pulse and pixel accounting. The count is
  // snapshotted on entry to ACK so frame_pixels is valid alongside frame_ack;
  // a write issued during ACK lands in the freshly cleared count.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= ST_IDLE;
      frame_ack    <= 1'b0;
      frame_pixels <= 17'd0;
      pix_count    <= 17'd0;
    end else begin
      state     <= state_nxt;
      frame_ack <= (state_nxt == ST_ACK);
      if (state_nxt == ST_ACK) begin
        frame_pixels <= pix_inc;
        pix_count    <= 17'd0;
      end else begin
        pix_count <= pix_inc;
      end
    end
  end

endmodule

// File: tb/tb_pixel_write_sink.sv
// Bench for pixel_write_sink: directed scenarios plus randomized traffic
// compared cycle by cycle against a queue-based reference model.
module tb_pixel_write_sink;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        wr_en = 1'b0;
  logic [8:0]  x_in = '0;
  logic [7:0]  y_in = '0;
  logic [2:0]  c_in = '0;
  logic        frame_done = 1'b0;
  logic        mem_busy = 1'b0;
  logic        mem_we;
  logic [16:0] mem_addr;
  logic [2:0]  mem_data;
  logic        fifo_full;
  logic        fifo_empty;
  logic        overflow;
  logic        frame_ack;
  logic [16:0] frame_pixels;
  logic [1:0]  state_out;

  pixel_write_sink dut (
    .clk          (clk),
    .resetn       (resetn),
    .wr_en        (wr_en),
    .x_in         (x_in),
    .y_in         (y_in),
    .c_in         (c_in),
    .frame_done   (frame_done),
    .mem_busy     (mem_busy),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .fifo_full    (fifo_full),
    .fifo_empty   (fifo_empty),
    .overflow     (overflow),
    .frame_ack    (frame_ack),
    .frame_pixels (frame_pixels),
    .state_out    (state_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [8:0] x;
    logic [7:0] y;
    logic [2:0] c;
  } pix_t;

  // Reference model: a plain queue of accepted writes plus the sticky flag.
  pix_t q[$];
  logic m_ovf;

  int n_checks = 0;
  int n_pass   = 0;

  // Monitor bookkeeping for the frame scenarios.
  int cyc = 0;
  int we_seen, last_we_cycle, ack_seen, ack_cycle, ack_pixels;
  logic saw_flush;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic bit on_screen(input int x, input int y);
`ifdef PIXEL_BOUNDS_CHECK_EN
    return (x < 320) && (y < 240);
`else
    return 1'b1;
`endif
  endfunction

  task automatic clear_monitor();
    we_seen = 0; last_we_cycle = -1; ack_seen = 0; ack_cycle = -1;
    ack_pixels = -1; saw_flush = 1'b0;
  endtask

  // One clock: drive inputs, advance the model, then compare after the edge.
  task automatic step(input logic wr, input int x, input int y, input int c,
                      input logic busy, input logic fd);
    pix_t p;
    pix_t exp_p;
    logic exp_we;
    wr_en = wr; x_in = x[8:0]; y_in = y[7:0]; c_in = c[2:0];
    mem_busy = busy; frame_done = fd;
    p = '{x: x[8:0], y: y[7:0], c: c[2:0]};
    exp_we = 1'b0;
    exp_p = '0;
    if (wr) begin
      // The queue may momentarily hold 9 here; the pop below restores 8.
      if (on_screen(x, y) && (q.size() < 8 || !busy)) q.push_back(p);
      else m_ovf = 1'b1;
    end
    if (!busy && q.size() > 0) begin
      exp_we = 1'b1;
      exp_p = q.pop_front();
    end
    @(posedge clk);
    #1;
    cyc++;
    check("mem_we", mem_we, exp_we);
    if (exp_we) begin
      check("mem_addr", mem_addr, exp_p.y * 320 + exp_p.x);
      check("mem_data", mem_data, exp_p.c);
    end
    check("fifo_full", fifo_full, q.size() == 8);
    check("fifo_empty", fifo_empty, q.size() == 0);
    check("overflow", overflow, m_ovf);
    if (mem_we) begin we_seen++; last_we_cycle = cyc; end
    if (frame_ack) begin ack_seen++; ack_cycle = cyc; ack_pixels = frame_pixels; end
    if (state_out == 2'd2) saw_flush = 1'b1;
  endtask

  // Asserts reset away from a clock edge, checks the cleared outputs at once,
  // then releases it and realigns to just after a rising edge.
  task automatic apply_reset(input string tag);
    wr_en = 1'b0; mem_busy = 1'b0; frame_done = 1'b0;
    resetn = 1'b0;
    #1;
    check({tag, "_mem_we"}, mem_we, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_data"}, mem_data, 0);
    check({tag, "_overflow"}, overflow, 0);
    check({tag, "_frame_ack"}, frame_ack, 0);
    check({tag, "_frame_pixels"}, frame_pixels, 0);
    check({tag, "_state"}, state_out, 0);
    check({tag, "_empty"}, fifo_empty, 1);
    check({tag, "_full"}, fifo_full, 0);
    q.delete();
    m_ovf = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    clear_monitor();
    #3;
    apply_reset("reset");

    // Single write reaches the port one clock later.
    step(1'b1, 140, 5, 7, 1'b0, 1'b0);
    check("single_addr", mem_addr, 1740);
    check("single_data", mem_data, 7);

    // Burst of 10 under busy: 8 queued, 2 dropped, then 8 drained in order.
    apply_reset("rst_burst");
    for (int i = 0; i < 10; i++)
      step(1'b1, $urandom_range(0, 319), $urandom_range(0, 239), $urandom_range(0, 7), 1'b1, 1'b0);
    check("burst_full", fifo_full, 1);
    check("burst_ovf", overflow, 1);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 0, 0, 0, 1'b0, 1'b0);
      if (mem_we) n++;
    end
    check("burst_drain_count", n, 8);

    // Full FIFO with simultaneous push and pop: nothing dropped.
    apply_reset("rst_full");
    for (int i = 0; i < 8; i++)
      step(1'b1, i * 30, i * 20, i, 1'b1, 1'b0);
    step(1'b1, 319, 239, 5, 1'b0, 1'b0);
    check("pushpop_ovf", overflow, 0);
    check("pushpop_full", fifo_full, 1);

    // Frame flush: 20 writes, frame_done rises with entries still queued.
    apply_reset("rst_frame");
    clear_monitor();
    for (int i = 0; i < 20; i++) begin
      step(1'b1, $urandom_range(0, 319), $urandom_range(0, 239), $urandom_range(0, 7),
           (i % 3) == 0, 1'b0);
      if (i == 0) check("frame_run_state", state_out, 1);
    end
    step(1'b0, 0, 0, 0, 1'b1, 1'b1);
    step(1'b0, 0, 0, 0, 1'b1, 1'b1);
    for (int i = 0; i < 40 && ack_seen == 0; i++)
      step(1'b0, 0, 0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++)
      step(1'b0, 0, 0, 0, 1'b0, 1'b1);
    check("frame_ack_pulses", ack_seen, 1);
    check("frame_pixels", ack_pixels, 20);
    check("frame_we_count", we_seen, 20);
    check("frame_saw_flush", saw_flush, 1);
    check("frame_ack_after_we", ack_cycle > last_we_cycle, 1);
    check("frame_back_idle", state_out, 0);

    // frame_done rising while idle goes straight to ACK with zero pixels.
    apply_reset("rst_idle_ack");
    step(1'b0, 0, 0, 0, 1'b0, 1'b1);
    check("idle_ack_pulse", frame_ack, 1);
    check("idle_ack_state", state_out, 3);
    check("idle_ack_pixels", frame_pixels, 0);
    step(1'b0, 0, 0, 0, 1'b0, 1'b1);
    check("idle_ack_done", frame_ack, 0);
    check("idle_ack_state2", state_out, 0);

    // Async reset mid-burst with 5 entries queued and a write issuing.
    apply_reset("rst_pre_async");
    for (int i = 0; i < 5; i++)
      step(1'b1, i + 10, i + 3, i, 1'b1, 1'b0);
    step(1'b1, 100, 100, 6, 1'b0, 1'b0);
    check("async_pre_we", mem_we, 1);
    #2;
    apply_reset("async");
    n = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 0, 0, 0, 1'b0, 1'b0);
      if (mem_we) n++;
    end
    check("async_no_we", n, 0);

    // Off-screen write at x=320, y=0.
    apply_reset("rst_bounds");
    step(1'b1, 320, 0, 3, 1'b0, 1'b0);
`ifdef PIXEL_BOUNDS_CHECK_EN
    check("bounds_ovf", overflow, 1);
    check("bounds_no_we", mem_we, 0);
`else
    check("bounds_we", mem_we, 1);
    check("bounds_addr", mem_addr, 320);
`endif

    // Randomized traffic against the reference model.
    apply_reset("rst_random");
    for (int i = 0; i < 400; i++)
      step(($urandom % 4) != 0, $urandom_range(0, 319), $urandom_range(0, 239),
           $urandom_range(0, 7), ($urandom % 3) == 0, 1'b0);
    for (int i = 0; i < 12; i++)
      step(1'b0, 0, 0, 0, 1'b0, 1'b0);
    check("random_drained", fifo_empty, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
